// File: rtl/jtframe_pdm_dac.sv
// jtframe_pdm_dac: CH-channel first-order sigma-delta PDM DAC with a per-channel gain-ramp soft mute.
// Define JTFRAME_PDM_DITHER_EN to add +/-1 LFSR dither in front of each accumulator.
module jtframe_pdm_dac #(
   parameter int            CH     = 2,
   parameter int            W      = 16,
   parameter logic [CH-1:0] SIGNED = '0,
   parameter int            DIV    = 4,
   parameter int            RAMPW  = 6
) (
   input  logic            clk_dac_i,
   input  logic            rst_i,
   input  logic [CH*W-1:0] snd_i,
   input  logic [CH-1:0]   mute_i,
   output logic [CH-1:0]   pdm_o,
   output logic [CH-1:0]   muted_o,
   output logic            cen_o
);

   localparam int               CNTW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(DIV - 1);
   localparam logic [W-1:0]     MID      = {1'b1, {(W-1){1'b0}}};
   localparam logic [RAMPW:0]   GMAX     = {1'b1, {RAMPW{1'b0}}};
   localparam logic [RAMPW:0]   G_ONE    = (RAMPW+1)'(1);

   typedef enum logic [1:0] {ST_MUTED, ST_FADE_IN, ST_PLAY, ST_FADE_OUT} state_t;

   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            cen_q, cen_d;
   logic [CH-1:0]   pdm_q, pdm_d, muted_q, muted_d;
   state_t          st_q [CH];
   state_t          st_d [CH];
   logic [RAMPW:0]  g_q  [CH];
   logic [RAMPW:0]  g_d  [CH];
   logic [W-1:0]    x_q  [CH];
   logic [W-1:0]    x_d  [CH];
   logic [W-1:0]    acc_q[CH];
   logic [W-1:0]    acc_d[CH];
   logic [W-1:0]    u_s  [CH];
   logic [W-1:0]    xa_s [CH];
   logic [W:0]      sum_s[CH];

   // Centre the sample on zero, scale by g/2^RAMPW (floor) and re-bias; result always fits W bits
   function automatic logic [W-1:0] pdm_scale(input logic [W-1:0] u, input logic [RAMPW:0] g);
      logic signed [W:0]         c;
      logic signed [W+RAMPW+1:0] p;
      c = $signed({1'b0, u}) - $signed({1'b0, MID});
      p = $signed({{(RAMPW+1){c[W]}}, c}) * $signed({{(W+1){1'b0}}, g});
      return W'(p >>> RAMPW) + MID;
   endfunction

`ifdef JTFRAME_PDM_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   function automatic logic [W-1:0] pdm_dither(input logic [W-1:0] x, input logic up);
      logic [W-1:0] r;
      if (up) begin
         r = (x == '1) ? x : x + W'(1);
      end else begin
         r = (x == '0) ? x : x - W'(1);
      end
      return r;
   endfunction

   // Galois LFSR x^16+x^14+x^13+x^11+1, one step per cen
   always_comb begin
      lfsr_d = lfsr_q;
      if (cen_q) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end else begin
         lfsr_d = lfsr_q;
      end
   end
`endif

   // Clock-enable divider: cen_q is high exactly while cnt_q == DIV-1
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNTW'(1);
      end
      cen_d = (cnt_d == CNT_LAST);
   end

   // Per-channel datapath and gain FSM; g moves by exactly one step per cen
   always_comb begin
      for (int n = 0; n < CH; n++) begin
         u_s[n] = snd_i[n*W +: W] ^ (SIGNED[n] ? MID : {W{1'b0}});
`ifdef JTFRAME_PDM_DITHER_EN
         xa_s[n] = pdm_dither(x_q[n], lfsr_q[n % 16]);
`else
         xa_s[n] = x_q[n];
`endif
         sum_s[n]   = {1'b0, acc_q[n]} + {1'b0, xa_s[n]};
         st_d[n]    = st_q[n];
         g_d[n]     = g_q[n];
         x_d[n]     = x_q[n];
         acc_d[n]   = acc_q[n];
         pdm_d[n]   = pdm_q[n];
         muted_d[n] = muted_q[n];
         if (cen_q) begin
            x_d[n]   = pdm_scale(u_s[n], g_q[n]);
            acc_d[n] = sum_s[n][W-1:0];
            pdm_d[n] = sum_s[n][W];
            case (st_q[n])
               ST_MUTED: begin
                  if (!mute_i[n]) begin
                     st_d[n] = ST_FADE_IN;
                     g_d[n]  = G_ONE;
                  end else begin
                     st_d[n] = ST_MUTED;
                     g_d[n]  = '0;
                  end
               end
               ST_FADE_IN, ST_FADE_OUT: begin
                  if (mute_i[n]) begin
                     g_d[n]  = g_q[n] - G_ONE;
                     st_d[n] = (g_q[n] == G_ONE) ? ST_MUTED : ST_FADE_OUT;
                  end else begin
                     g_d[n]  = g_q[n] + G_ONE;
                     st_d[n] = (g_q[n] == GMAX - G_ONE) ? ST_PLAY : ST_FADE_IN;
                  end
               end
               ST_PLAY: begin
                  if (mute_i[n]) begin
                     st_d[n] = ST_FADE_OUT;
                     g_d[n]  = GMAX - G_ONE;
                  end else begin
                     st_d[n] = ST_PLAY;
                     g_d[n]  = GMAX;
                  end
               end
               default: begin
                  st_d[n] = ST_MUTED;
                  g_d[n]  = '0;
               end
            endcase
            muted_d[n] = (st_d[n] == ST_MUTED);
         end else begin
            muted_d[n] = muted_q[n];
         end
      end
   end

   // State registers with synchronous reset to the silent state
   always_ff @(posedge clk_dac_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         cen_q   <= 1'b0;
         pdm_q   <= '0;
         muted_q <= '1;
         for (int n = 0; n < CH; n++) begin
            st_q[n]  <= ST_MUTED;
            g_q[n]   <= '0;
            x_q[n]   <= MID;
            acc_q[n] <= '0;
         end
`ifdef JTFRAME_PDM_DITHER_EN
         lfsr_q  <= 16'hACE1;
`endif
      end else begin
         cnt_q   <= cnt_d;
         cen_q   <= cen_d;
         pdm_q   <= pdm_d;
         muted_q <= muted_d;
         for (int n = 0; n < CH; n++) begin
            st_q[n]  <= st_d[n];
            g_q[n]   <= g_d[n];
            x_q[n]   <= x_d[n];
            acc_q[n] <= acc_d[n];
         end
`ifdef JTFRAME_PDM_DITHER_EN
         lfsr_q  <= lfsr_d;
`endif
      end
   end

   assign pdm_o   = pdm_q;
   assign muted_o = muted_q;
   assign cen_o   = cen_q;

endmodule
